// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I word and register-index types
package rv32i_types;
  typedef logic [31:0] rv32i_word;
  typedef logic [4:0] rv32i_reg;
endpackage

// File: rtl/sb_pkg.sv
// sb_pkg: scoreboard sizing constants and pending-count type
package sb_pkg;
  localparam int SB_NREGS = 32;
  localparam int SB_PEND_W = 2;
  typedef logic [SB_PEND_W-1:0] pend_cnt_t;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating pending-write counter with two decrement sources and underflow pulse
module sb_counter
  import sb_pkg::*;
#(
  parameter int W = SB_PEND_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec_a,
  input  logic         dec_b,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);
  logic [W+1:0] sum;
  assign sum = {2'b00, count} + (W+2)'(inc) - (W+2)'(dec_a) - (W+2)'(dec_b);
  assign underflow = sum[W+1];
  assign full = &count;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else count <= underflow ? '0 : sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: RV32I register file with pending-write scoreboard; define REGFILE_BYPASS_EN for same-cycle writeback forwarding
module regfile_scoreboard
  import rv32i_types::*, sb_pkg::*;
#(
  parameter int PEND_W = SB_PEND_W
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      issue_valid,
  input  logic      issue_ld_reg,
  input  rv32i_reg  issue_rd,
  input  rv32i_reg  rs1_sel,
  input  rv32i_reg  rs2_sel,
  output rv32i_word rs1_out,
  output rv32i_word rs2_out,
  output logic      rs1_busy,
  output logic      rs2_busy,
  output logic      stall,
  input  logic      load_reg,
  input  rv32i_reg  rd_sel,
  input  rv32i_word regfilemux_out,
  input  logic      squash_valid,
  input  rv32i_reg  squash_rd,
  output logic      sb_error
);
  rv32i_word regs [1:SB_NREGS-1];
  logic [PEND_W-1:0] cnt [SB_NREGS];
  logic [SB_NREGS-1:0] full, uf;
  logic inc, dec_wb, dec_sq;
  assign inc = issue_valid && issue_ld_reg && !stall && issue_rd != '0;
  assign dec_wb = load_reg && rd_sel != '0;
  assign dec_sq = squash_valid && squash_rd != '0;
  assign cnt[0] = '0;
  assign full[0] = 1'b0;
  assign uf[0] = 1'b0;
  for (genvar i = 1; i < SB_NREGS; i++) begin : g_cnt
    sb_counter #(.W(PEND_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .inc      (inc && issue_rd == rv32i_reg'(i)),
      .dec_a    (dec_wb && rd_sel == rv32i_reg'(i)),
      .dec_b    (dec_sq && squash_rd == rv32i_reg'(i)),
      .count    (cnt[i]),
      .full     (full[i]),
      .underflow(uf[i])
    );
  end
  function automatic logic busy(input rv32i_reg s);
`ifdef REGFILE_BYPASS_EN
    return s != '0 && {1'b0, cnt[s]} >
      (PEND_W+1)'(dec_wb && rd_sel == s) + (PEND_W+1)'(dec_sq && squash_rd == s);
`else
    return s != '0 && cnt[s] != '0;
`endif
  endfunction
  function automatic rv32i_word rd(input rv32i_reg s);
`ifdef REGFILE_BYPASS_EN
    return s == '0 ? '0 : (dec_wb && rd_sel == s) ? regfilemux_out : regs[s];
`else
    return s == '0 ? '0 : regs[s];
`endif
  endfunction
  assign rs1_busy = busy(rs1_sel);
  assign rs2_busy = busy(rs2_sel);
  assign rs1_out = rd(rs1_sel);
  assign rs2_out = rd(rs2_sel);
  // a saturated destination may still issue if the same cycle retires or squashes one of its writes
  assign stall = (issue_valid && (rs1_busy || rs2_busy)) ||
                 (issue_ld_reg && issue_rd != '0 && full[issue_rd] &&
                  !(dec_wb && rd_sel == issue_rd) && !(dec_sq && squash_rd == issue_rd));
  always_ff @(posedge clk)
    if (rst) for (int k = 1; k < SB_NREGS; k++) regs[k] <= '0;
    else if (dec_wb) regs[rd_sel] <= regfilemux_out;
  always_ff @(posedge clk)
    if (rst) sb_error <= 1'b0;
    else if (|uf) sb_error <= 1'b1;
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Architectural register file plus per-register pending-write scoreboard for the RV32I pipeline. It receives the writeback stage's register write (`load_reg`, `rd_sel`, `regfilemux_out`) and serves decode's two combinational read ports. It tracks in-flight destination registers issued from decode and raises `stall` on a RAW hazard. It also holds a sticky protocol-error flag for the verifier.

## Interface
Parameters:
- `PEND_W`, default 2: width of each per-register pending counter; max in-flight writes per register is 2^PEND_W−1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous active-high reset
- `issue_valid`  in  1  decode hands an instruction to ID/EX this cycle
- `issue_ld_reg`  in  1  issued instruction writes a register
- `issue_rd`  in  5  destination of issued instruction
- `rs1_sel`, `rs2_sel`  in  5 each  decode source register indices
- `rs1_out`, `rs2_out`  out  32 each  source read data
- `rs1_busy`, `rs2_busy`  out  1 each  source has a pending write
- `stall`  out  1  decode must not issue this cycle
- `load_reg`  in  1  writeback register write enable
- `rd_sel`  in  5  writeback destination
- `regfilemux_out`  in  32  writeback data (rv32i_word)
- `squash_valid`  in  1  one already-issued register-writing instruction is flushed
- `squash_rd`  in  5  destination of squashed instruction
- `sb_error`  out  1  sticky: retire or squash hit a register with zero pending count

## Operation
- Storage: 31 × 32-bit registers, x1–x31; x0 is not stored and always reads 0.
- Write: at posedge, if `load_reg` and `rd_sel`≠0, set reg[rd_sel] to `regfilemux_out`.
- Counters: one PEND_W-bit count per register, x1–x31.
  - inc = `issue_valid && issue_ld_reg && !stall && issue_rd≠0`
  - dec_wb = `load_reg && rd_sel≠0`
  - dec_sq = `squash_valid && squash_rd≠0`
  - next count = count + inc − dec_wb − dec_sq, applied per register; all three may target the same register in one cycle.
- Underflow: a decrement with count 0 leaves count at 0 and sets `sb_error`, which holds until reset.
- `rsN_busy` = rsN_sel≠0 and effective count≠0.
  - With bypass: effective count = count − dec_wb(rsN_sel) − dec_sq(rsN_sel), floored at 0.
  - Without bypass: effective count = count.
- `stall` asserts, combinationally, when either:
  - `issue_valid` and (`rs1_busy` or `rs2_busy`); or
  - `issue_ld_reg`, `issue_rd`≠0, and count[issue_rd] is saturated at 2^PEND_W−1 and not being decremented this cycle.
- An issue while `stall` is high has no effect on the counters.
- Read data: `rsN_out` = 0 if sel=0, otherwise reg[sel]; write-through forwarding is governed by Configuration.

## Timing
- Reads, busy flags and `stall` are combinational, with zero-cycle latency.
- Writes and counter updates take effect at the next rising edge and are visible in the following cycle.
- Reset, synchronous: all registers = 0, all counts = 0, `sb_error` = 0. Consequently after reset `rsN_out` = 0, `rsN_busy` = 0 and `stall` = 0.
- Reset wins over any simultaneous issue, writeback or squash in the same cycle.
- Same-cycle issue and writeback to the same rd: count is unchanged, and the data write happens.
- Same-cycle writeback and read of the same register: behaviour depends on Configuration.
- Writes to x0: data is dropped, no counter change, no `sb_error`.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - A writeback to reg r in cycle t is forwarded: `rsN_out` = `regfilemux_out` in cycle t when rsN_sel=r≠0.
  - `rsN_busy` already accounts for that cycle's retire, so a dependent instruction issues in the retire cycle.
- Not defined:
  - `rsN_out` returns stored data only.
  - `rsN_busy` drops one cycle after the retire, so a dependent instruction issues one cycle later.

## Structure
- `rv32i_types` supplies rv32i_word and rv32i_reg.
- A shared package `sb_pkg` adds:
  - `SB_NREGS` = 32
  - a pend_cnt_t typedef, sized by PEND_W
- Sub-module `sb_counter`: one saturating up/down counter with inputs inc, dec_a, dec_b. Outputs:
  - count
  - full
  - underflow pulse, which feeds the `sb_error` OR-tree
- It is instantiated 31 times, for x1–x31.

## Test plan
- Reset then read: `rst`=1 for 2 cycles, rs1_sel=5 and rs2_sel=0 → rs1_out=0, rs2_out=0, busy=0, stall=0, sb_error=0.
- RAW stall:
  - Issue rd=3, ld_reg=1. Next cycle issue with rs1_sel=3 → stall=1.
  - Writeback load_reg=1, rd_sel=3, data 0xDEADBEEF.
  - With `REGFILE_BYPASS_EN`: stall=0 that cycle and rs1_out=0xDEADBEEF.
  - Without it: stall=0 one cycle later.
- Multiple in-flight writes:
  - Issue rd=7 three times (PEND_W=2) → count=3, and a fourth issue to rd=7 sees stall=1.
  - One writeback to x7 → count=2, and the fourth issue is accepted.
- Squash and underflow:
  - Issue rd=9, then squash_rd=9 → busy(9)=0, sb_error=0.
  - A further squash_rd=9 → sb_error=1 and it stays 1 until reset.
- x0 handling: issue rd=0, then writeback rd_sel=0 with data 0x1234 → rs1_sel=0 reads 0, no stall, no sb_error.
- Simultaneous events: same cycle issue rd=4, writeback rd_sel=4 and reset=1 → next cycle all counts 0 and reg[4]=0.
